// File: rtl/mtx_addr_gen.sv
// Matrix-operand word-address generator: row/column stepping with element counting,
// end-of-vector pulse and optional advance to the next column.
module mtx_addr_gen #(
   parameter int unsigned AW = 10,
   parameter int unsigned LW = 4
) (
   input  logic          sys_clk,
   input  logic          reset,
   input  logic          cntld,
   input  logic [AW-1:0] ld_addr,
   input  logic          cnten,
   input  logic          maddw,
   input  logic          colwrap,
   input  logic [LW-1:0] mwidth,
   input  logic [LW-1:0] mlen,
   output logic [AW-1:0] maddr,
   output logic          last,
   output logic          done
);

   logic [AW-1:0] maddr_q, maddr_d;
   logic [AW-1:0] col_base_q, col_base_d;
   logic [LW-1:0] elem_cnt_q, elem_cnt_d;
   logic          mode_col_q, mode_col_d;
   logic          mode_wrap_q, mode_wrap_d;
   logic [LW-1:0] width_q, width_d;
   logic [LW-1:0] len_q, len_d;
   logic          done_q, done_d;

   logic [AW-1:0] stride;
   logic [LW-1:0] len_m1;
   logic          at_end;
   logic [AW-1:0] next_addr;

   // A zero length field means 2^LW, so len-1 modulo 2^LW is exactly len_eff-1.
   assign len_m1 = len_q - LW'(1);
   assign at_end = (elem_cnt_q == len_m1);

   always_comb begin
      stride = AW'(1);
      if (mode_col_q) begin
         stride = (width_q == '0) ? (AW'(1) << LW) : AW'(width_q);
      end
   end

   assign next_addr = maddr_q + stride;

   always_comb begin
      maddr_d     = maddr_q;
      col_base_d  = col_base_q;
      elem_cnt_d  = elem_cnt_q;
      mode_col_d  = mode_col_q;
      mode_wrap_d = mode_wrap_q;
      width_d     = width_q;
      len_d       = len_q;
      done_d      = 1'b0;
      if (cntld) begin
         maddr_d     = ld_addr;
         col_base_d  = ld_addr;
         elem_cnt_d  = '0;
         mode_col_d  = maddw;
         mode_wrap_d = colwrap;
         width_d     = mwidth;
         len_d       = mlen;
      end else if (cnten) begin
         if (at_end) begin
            elem_cnt_d = '0;
            done_d     = 1'b1;
            if (mode_col_q && mode_wrap_q) begin
               maddr_d    = col_base_q + AW'(1);
               col_base_d = col_base_q + AW'(1);
            end else begin
               maddr_d    = next_addr;
               col_base_d = next_addr;
            end
         end else begin
            maddr_d    = next_addr;
            elem_cnt_d = elem_cnt_q + LW'(1);
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         maddr_q     <= '0;
         col_base_q  <= '0;
         elem_cnt_q  <= '0;
         mode_col_q  <= 1'b0;
         mode_wrap_q <= 1'b0;
         width_q     <= '0;
         len_q       <= '0;
         done_q      <= 1'b0;
      end else begin
         maddr_q     <= maddr_d;
         col_base_q  <= col_base_d;
         elem_cnt_q  <= elem_cnt_d;
         mode_col_q  <= mode_col_d;
         mode_wrap_q <= mode_wrap_d;
         width_q     <= width_d;
         len_q       <= len_d;
         done_q      <= done_d;
      end
   end

   assign maddr = maddr_q;
   assign last  = at_end;
   assign done  = done_q;

endmodule

// File: tb/tb_mtx_addr_gen.sv
// Bench for mtx_addr_gen: directed vector table, hand sequences and random walk
// against an arithmetic reference model.
module tb_mtx_addr_gen;
   localparam int unsigned AW = 10;
   localparam int unsigned LW = 4;
   localparam int ASIZE = 1 << AW;
   localparam int LMAX  = 1 << LW;

   logic          sys_clk = 1'b0;
   logic          reset   = 1'b1;
   logic          cntld   = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic          cnten   = 1'b0;
   logic          maddw   = 1'b0;
   logic          colwrap = 1'b0;
   logic [LW-1:0] mwidth  = '0;
   logic [LW-1:0] mlen    = '0;
   logic [AW-1:0] maddr;
   logic          last;
   logic          done;

   int errors = 0;
   int checks = 0;

   always #5 sys_clk = ~sys_clk;

   mtx_addr_gen #(.AW(AW), .LW(LW)) dut (
      .sys_clk (sys_clk),
      .reset   (reset),
      .cntld   (cntld),
      .ld_addr (ld_addr),
      .cnten   (cnten),
      .maddw   (maddw),
      .colwrap (colwrap),
      .mwidth  (mwidth),
      .mlen    (mlen),
      .maddr   (maddr),
      .last    (last),
      .done    (done)
   );

   typedef struct {
      bit rst; bit ld; bit en;
      int addr; bit col; bit wrap; int w; int len;
      int e_maddr; bit e_last; bit e_done;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit rst, bit ld, bit en, int addr, bit col, bit wrap, int w,
                               int len, int em, bit el, bit ed);
      vec_t v;
      v.rst = rst; v.ld = ld; v.en = en; v.addr = addr; v.col = col; v.wrap = wrap;
      v.w = w; v.len = len; v.e_maddr = em; v.e_last = el; v.e_done = ed;
      return v;
   endfunction

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply(bit rst, bit ld, bit en, int addr, bit col, bit wrap, int w, int len);
      reset   = rst;
      cntld   = ld;
      cnten   = en;
      ld_addr = AW'(addr);
      maddw   = col;
      colwrap = wrap;
      mwidth  = LW'(w);
      mlen    = LW'(len);
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check_out(string tag, int em, bit el, bit ed);
      check({tag, " maddr"}, int'(maddr), em);
      check({tag, " last"}, int'(last), int'(el));
      check({tag, " done"}, int'(done), int'(ed));
   endtask

   // Reference model: walk described as base address, element index and latched mode.
   int  m_addr, m_base, m_cnt, m_w, m_len;
   bit  m_col, m_wrap, m_done;

   function automatic int m_leff();
      return (m_len == 0) ? LMAX : m_len;
   endfunction

   task automatic model(bit rst, bit ld, bit en, int addr, bit col, bit wrap, int w, int len);
      int stride;
      if (rst) begin
         m_addr = 0; m_base = 0; m_cnt = 0; m_w = 0; m_len = 0;
         m_col = 0; m_wrap = 0; m_done = 0;
      end else if (ld) begin
         m_addr = addr; m_base = addr; m_cnt = 0;
         m_col = col; m_wrap = wrap; m_w = w; m_len = len; m_done = 0;
      end else if (en) begin
         stride = m_col ? ((m_w == 0) ? LMAX : m_w) : 1;
         if (m_cnt == m_leff() - 1) begin
            m_cnt  = 0;
            m_done = 1;
            if (m_col && m_wrap) begin
               m_base = (m_base + 1) % ASIZE;
               m_addr = m_base;
            end else begin
               m_addr = (m_addr + stride) % ASIZE;
               m_base = m_addr;
            end
         end else begin
            m_addr = (m_addr + stride) % ASIZE;
            m_cnt++;
            m_done = 0;
         end
      end else begin
         m_done = 0;
      end
   endtask

   initial begin
      // Reset, idle, then one step in reset (row) mode.
      vecs.push_back(mk(1,0,0, 0,0,0,0,0, 'h000,0,0));
      repeat (3) vecs.push_back(mk(0,0,0, 0,0,0,0,0, 'h000,0,0));
      vecs.push_back(mk(0,0,1, 0,0,0,0,0, 'h001,0,0));
      // Row mode, length 4.
      vecs.push_back(mk(0,1,0, 'h3F0,0,0,0,4, 'h3F0,0,0));
      vecs.push_back(mk(0,0,1, 0,0,0,0,0, 'h3F1,0,0));
      vecs.push_back(mk(0,0,1, 0,0,0,0,0, 'h3F2,0,0));
      vecs.push_back(mk(0,0,1, 0,0,0,0,0, 'h3F3,1,0));
      vecs.push_back(mk(0,0,1, 0,0,0,0,0, 'h3F4,0,1));
      vecs.push_back(mk(0,0,1, 0,0,0,0,0, 'h3F5,0,0));
      // Address wrap across the top of memory.
      vecs.push_back(mk(0,1,0, 'h3FE,0,0,0,4, 'h3FE,0,0));
      vecs.push_back(mk(0,0,1, 0,0,0,0,0, 'h3FF,0,0));
      vecs.push_back(mk(0,0,1, 0,0,0,0,0, 'h000,0,0));
      vecs.push_back(mk(0,0,1, 0,0,0,0,0, 'h001,1,0));
      // Column mode without wrap, idle after done.
      vecs.push_back(mk(0,1,0, 'h100,1,0,4,3, 'h100,0,0));
      vecs.push_back(mk(0,0,1, 0,0,0,0,0, 'h104,0,0));
      vecs.push_back(mk(0,0,1, 0,0,0,0,0, 'h108,1,0));
      vecs.push_back(mk(0,0,1, 0,0,0,0,0, 'h10C,0,1));
      vecs.push_back(mk(0,0,0, 0,0,0,0,0, 'h10C,0,0));
      vecs.push_back(mk(0,0,1, 0,0,0,0,0, 'h110,0,0));
      // Column wrap.
      vecs.push_back(mk(0,1,0, 'h100,1,1,4,3, 'h100,0,0));
      vecs.push_back(mk(0,0,1, 0,0,0,0,0, 'h104,0,0));
      vecs.push_back(mk(0,0,1, 0,0,0,0,0, 'h108,1,0));
      vecs.push_back(mk(0,0,1, 0,0,0,0,0, 'h101,0,1));
      vecs.push_back(mk(0,0,1, 0,0,0,0,0, 'h105,0,0));
      vecs.push_back(mk(0,0,1, 0,0,0,0,0, 'h109,1,0));
      vecs.push_back(mk(0,0,1, 0,0,0,0,0, 'h102,0,1));
      // Load beats step; mode inputs ignored between loads.
      vecs.push_back(mk(0,1,1, 'h055,1,0,4,3, 'h055,0,0));
      vecs.push_back(mk(0,0,1, 0,1,0,8,3, 'h059,0,0));
      vecs.push_back(mk(0,0,1, 0,0,1,8,7, 'h05D,1,0));
      // Reset mid-walk clears mode latches too.
      vecs.push_back(mk(0,1,0, 'h100,1,1,4,3, 'h100,0,0));
      vecs.push_back(mk(0,0,1, 0,0,0,0,0, 'h104,0,0));
      vecs.push_back(mk(0,0,1, 0,0,0,0,0, 'h108,1,0));
      vecs.push_back(mk(0,0,1, 0,0,0,0,0, 'h101,0,1));
      vecs.push_back(mk(0,0,1, 0,0,0,0,0, 'h105,0,0));
      vecs.push_back(mk(0,0,1, 0,0,0,0,0, 'h109,1,0));
      vecs.push_back(mk(1,0,1, 0,0,0,0,0, 'h000,0,0));
      vecs.push_back(mk(0,0,1, 0,0,0,0,0, 'h001,0,0));

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].rst, vecs[i].ld, vecs[i].en, vecs[i].addr, vecs[i].col, vecs[i].wrap,
               vecs[i].w, vecs[i].len);
         check_out($sformatf("vec%0d", i), vecs[i].e_maddr, vecs[i].e_last, vecs[i].e_done);
      end

      // Zero fields: stride 16, length 16.
      apply(0,1,0, 'h000,1,0,0,0);
      check_out("zero ld", 'h000, 0, 0);
      for (int i = 1; i <= 16; i++) begin
         apply(0,0,1, 0,0,0,0,0);
         check_out($sformatf("zero s%0d", i), (16 * i) % ASIZE, i == 15, i == 16);
      end

      // Length 1 with column wrap from the last word.
      apply(0,1,0, 'h3FF,1,1,5,1);
      check_out("len1 ld", 'h3FF, 1, 0);
      apply(0,0,1, 0,0,0,0,0);
      check_out("len1 s1", 'h000, 1, 1);
      apply(0,0,1, 0,0,0,0,0);
      check_out("len1 s2", 'h001, 1, 1);
      apply(0,0,0, 0,0,0,0,0);
      check_out("len1 idle", 'h001, 1, 0);

      // Random walk against the reference model.
      apply(1,0,0, 0,0,0,0,0);
      model(1,0,0, 0,0,0,0,0);
      for (int i = 0; i < 3000; i++) begin
         bit r, l, e, c, wr;
         int a, w, n;
         r  = ($urandom_range(0, 99) == 0);
         l  = ($urandom_range(0, 9) == 0);
         e  = ($urandom_range(0, 3) != 0);
         a  = $urandom_range(0, ASIZE - 1);
         c  = $urandom_range(0, 1);
         wr = $urandom_range(0, 1);
         w  = $urandom_range(0, LMAX - 1);
         n  = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 4) : $urandom_range(0, LMAX - 1);
         apply(r, l, e, a, c, wr, w, n);
         model(r, l, e, a, c, wr, w, n);
         check_out($sformatf("rand%0d", i), m_addr, m_cnt == m_leff() - 1, m_done);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
